// File: rtl/bus_arbiter_ctrl.sv
// Two-master round-robin bus arbiter with address/data phase control.
// Outputs are decoded from registered state; status pulses are registered.
module bus_arbiter_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hbusreq1,
  input  logic       hbusreq2,
  input  logic       hwrite1,
  input  logic       hwrite2,
  input  logic       rdyout,
  input  logic [1:0] respout,
  output logic       hgrant1,
  output logic       hgrant2,
  output logic       sel1,
  output logic       sel2,
  output logic       mux1,
  output logic       sel3,
  output logic       sel4,
  output logic       mux2,
  output logic       Aout,
  output logic       Dout,
  output logic       hdone,
  output logic       herr,
  output logic       htimeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          own_q, own_d;
  logic          wflag_q, wflag_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          to_q, to_d;

  logic any_req;
  logic win_idle;
  logic win_b2b;
  logic own_wr;

  // Owner encoding: 0 = master 1, 1 = master 2.
  assign any_req  = hbusreq1 | hbusreq2;
  assign win_idle = (hbusreq1 & hbusreq2) ? ~last_q : ~hbusreq1;
  assign win_b2b  = (hbusreq1 & hbusreq2) ? ~own_q : ~hbusreq1;
  assign own_wr   = own_q ? hwrite2 : hwrite1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      wflag_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      wflag_q <= wflag_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    wflag_d = wflag_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ADDR;
          own_d   = win_idle;
          wflag_d = win_idle ? hwrite2 : hwrite1;
        end
      end
      ADDR: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (rdyout) begin
          if (respout == 2'b10) begin
            state_d = ADDR;
            wflag_d = own_wr;
            cnt_d   = '0;
          end else begin
            done_d = 1'b1;
            err_d  = (respout == 2'b01);
            last_d = own_q;
            if (any_req) begin
              state_d = ADDR;
              own_d   = win_b2b;
              wflag_d = win_b2b ? hwrite2 : hwrite1;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (cnt_q >= CLAST) begin
          to_d    = 1'b1;
          err_d   = 1'b1;
          last_d  = own_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic busy;
  assign busy = (state_q != IDLE);

  assign hgrant1  = busy & ~own_q;
  assign hgrant2  = busy & own_q;
  assign mux1     = busy & own_q;
  assign mux2     = busy & own_q;
  assign sel1     = (state_q == ADDR) & ~own_q;
  assign sel2     = (state_q == ADDR) & own_q;
  assign sel3     = (state_q == ADDR) & ~own_q & wflag_q;
  assign sel4     = (state_q == ADDR) & own_q & wflag_q;
  assign Aout     = (state_q == DATA);
  assign Dout     = (state_q == DATA) & wflag_q;
  assign hdone    = done_q;
  assign herr     = err_q;
  assign htimeout = to_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Vector table plus scoreboard bench for bus_arbiter_ctrl.
// Output bit order: g1 g2 s1 s2 s3 s4 m1 m2 A D done err tout.
module tb_bus_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       hbusreq1, hbusreq2;
  logic       hwrite1, hwrite2;
  logic       rdyout;
  logic [1:0] respout;
  logic       hgrant1, hgrant2;
  logic       sel1, sel2, sel3, sel4;
  logic       mux1, mux2;
  logic       Aout, Dout;
  logic       hdone, herr, htimeout;

  int total = 0;
  int bad = 0;

  bus_arbiter_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .hbusreq1(hbusreq1), .hbusreq2(hbusreq2),
    .hwrite1(hwrite1), .hwrite2(hwrite2),
    .rdyout(rdyout), .respout(respout),
    .hgrant1(hgrant1), .hgrant2(hgrant2),
    .sel1(sel1), .sel2(sel2),
    .mux1(mux1), .sel3(sel3), .sel4(sel4), .mux2(mux2),
    .Aout(Aout), .Dout(Dout),
    .hdone(hdone), .herr(herr), .htimeout(htimeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r1, r2, w1, w2, rdy;
    logic [1:0]  resp;
    logic [12:0] exp;
  } vec_t;

  logic [12:0] sbq[$];

  function automatic logic [12:0] outs();
    return {hgrant1, hgrant2, sel1, sel2, sel3, sel4,
            mux1, mux2, Aout, Dout, hdone, herr, htimeout};
  endfunction

  // ADDR phase for master m (0 = master 1), write w, plus pulses.
  function automatic logic [12:0] ea(bit m, bit w, bit dn, bit er);
    if (!m) return {1'b1, 1'b0, 1'b1, 1'b0, w, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, dn, er, 1'b0};
    return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, w,
            1'b1, 1'b1, 1'b0, 1'b0, dn, er, 1'b0};
  endfunction

  function automatic logic [12:0] ed(bit m, bit w);
    return {~m, m, 4'b0000, m, m, 1'b1, w, 3'b000};
  endfunction

  function automatic logic [12:0] ei(bit dn, bit er, bit to);
    return {10'b0, dn, er, to};
  endfunction

  function automatic vec_t mk(bit r1, bit r2, bit w1, bit w2,
                              bit rdy, logic [1:0] rs,
                              logic [12:0] e);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.w1 = w1; v.w2 = w2;
    v.rdy = rdy; v.resp = rs; v.exp = e;
    return v;
  endfunction

  task automatic check(input string tag, input logic [12:0] act,
                       input logic [12:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, act, req);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic [12:0] e;
    @(negedge clk);
    hbusreq1 = v.r1; hbusreq2 = v.r2;
    hwrite1 = v.w1; hwrite2 = v.w2;
    rdyout = v.rdy; respout = v.resp;
    sbq.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      check(tag, outs(), e);
    end
  endtask

  vec_t tbl[29];

  initial begin
    // single read, master 1, request dropped mid-transfer
    tbl[0]  = mk(1,0,0,0,0,2'b00, ea(0,0,0,0));
    tbl[1]  = mk(0,0,0,0,1,2'b00, ed(0,0));
    tbl[2]  = mk(0,0,0,0,1,2'b00, ei(1,0,0));
    tbl[3]  = mk(0,0,0,0,0,2'b00, ei(0,0,0));
    // write, master 2, three wait states
    tbl[4]  = mk(0,1,0,1,0,2'b00, ea(1,1,0,0));
    tbl[5]  = mk(0,0,0,1,0,2'b00, ed(1,1));
    tbl[6]  = mk(0,0,0,1,0,2'b00, ed(1,1));
    tbl[7]  = mk(0,0,0,1,0,2'b00, ed(1,1));
    tbl[8]  = mk(0,0,0,1,0,2'b00, ed(1,1));
    tbl[9]  = mk(0,0,0,1,1,2'b00, ei(1,0,0));
    // contention, back-to-back
    tbl[10] = mk(1,1,0,0,1,2'b00, ea(0,0,0,0));
    tbl[11] = mk(1,1,0,0,1,2'b00, ed(0,0));
    tbl[12] = mk(1,1,0,0,1,2'b00, ea(1,0,1,0));
    tbl[13] = mk(1,1,0,0,1,2'b00, ed(1,0));
    tbl[14] = mk(1,1,0,0,1,2'b00, ea(0,0,1,0));
    tbl[15] = mk(1,1,0,0,1,2'b00, ed(0,0));
    tbl[16] = mk(0,0,0,0,1,2'b00, ei(1,0,0));
    // retry then okay, master 1 write
    tbl[17] = mk(1,0,1,0,0,2'b00, ea(0,1,0,0));
    tbl[18] = mk(1,0,1,0,0,2'b00, ed(0,1));
    tbl[19] = mk(1,0,1,0,1,2'b10, ea(0,1,0,0));
    tbl[20] = mk(1,0,1,0,0,2'b00, ed(0,1));
    tbl[21] = mk(0,0,1,0,1,2'b00, ei(1,0,0));
    // error response, master 2 read
    tbl[22] = mk(0,1,0,0,0,2'b00, ea(1,0,0,0));
    tbl[23] = mk(0,0,0,0,0,2'b00, ed(1,0));
    tbl[24] = mk(0,0,0,0,1,2'b01, ei(1,1,0));
    // response 11 acts as okay
    tbl[25] = mk(1,0,0,0,0,2'b00, ea(0,0,0,0));
    tbl[26] = mk(0,0,0,0,0,2'b00, ed(0,0));
    tbl[27] = mk(0,0,0,0,1,2'b11, ei(1,0,0));
    tbl[28] = mk(0,0,0,0,0,2'b00, ei(0,0,0));

    rst = 1'b1;
    hbusreq1 = 0; hbusreq2 = 0; hwrite1 = 0; hwrite2 = 0;
    rdyout = 0; respout = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 13'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 29; i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // timeout: master 2 read, never ready
    step(mk(0,1,0,0,0,2'b00, ea(1,0,0,0)), "to_addr");
    for (int k = 0; k < 16; k++)
      step(mk(0,0,0,0,0,2'b00, ed(1,0)), $sformatf("to_wait%0d", k));
    step(mk(0,0,0,0,0,2'b00, ei(0,1,1)), "to_pulse");
    step(mk(0,0,0,0,0,2'b00, ei(0,0,0)), "to_idle");

    // leave pointer on master 1 before the reset test
    step(mk(1,0,0,0,0,2'b00, ea(0,0,0,0)), "pre_addr");
    step(mk(0,0,0,0,0,2'b00, ed(0,0)), "pre_data");
    step(mk(0,0,0,0,1,2'b00, ei(1,0,0)), "pre_done");

    // async reset mid-DATA with ready already pending
    step(mk(1,0,1,0,0,2'b00, ea(0,1,0,0)), "rst_addr");
    step(mk(1,1,1,0,1,2'b00, ed(0,1)), "rst_data");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", outs(), 13'b0);
    @(posedge clk);
    #1;
    check("rst_hold", outs(), 13'b0);
    @(negedge clk);
    hbusreq1 = 0; hbusreq2 = 0; hwrite1 = 0; rdyout = 0;
    rst = 1'b0;
    step(mk(0,0,0,0,0,2'b00, ei(0,0,0)), "post_rst_idle");

    // contention from reset pointer: 1,2,1,2
    for (int k = 0; k < 4; k++) begin
      step(mk(1,1,0,0,1,2'b00, ea(k[0], 0, k > 0, 0)),
           $sformatf("rr_addr%0d", k));
      step(mk(1,1,0,0,k < 3,2'b00, ed(k[0], 0)),
           $sformatf("rr_data%0d", k));
    end
    step(mk(0,0,0,0,1,2'b00, ei(1,0,0)), "rr_done");
    step(mk(0,0,0,0,0,2'b00, ei(0,0,0)), "rr_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk)
    if (!rst && hgrant1 && hgrant2) begin
      total++; bad++;
      $display("FAIL onehot: g1=%b g2=%b want not both", hgrant1, hgrant2);
    end

endmodule
